// File: rtl/enum_type.sv
// Shared tetris enums and constants used by the core and its command scheduler.
package enum_type;

    typedef enum logic [3:0] {
        NONE,
        INIT,
        GEN,
        WAIT,
        LEFT,
        RIGHT,
        DOWN,
        DROP,
        ROTATE,
        ROTATE_REV,
        HOLD,
        BAR,
        CLEAR,
        END
    } state_type;

    localparam int BCD_W = 4;
    localparam int BAR_WIDTH = 10;
    localparam logic [BAR_WIDTH-1:0] LFSR_SEED = 10'h001;

endpackage

// File: rtl/tetris_cmd_sched_cmd_fifo.sv
// Synchronous command FIFO of state_type entries with flush; DEPTH must be a power of 2.
module cmd_fifo
    import enum_type::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  state_type din,
    output state_type dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_type mem_q [DEPTH];
    state_type mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = din;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/tetris_cmd_sched.sv
// Merges buttons, gravity and garbage bars into the core's ctrl stream, issuing only in WAIT.
// Optional DAS auto-repeat on hold_left/hold_right is enabled by TETRIS_AUTO_REPEAT_EN.
module tetris_cmd_sched
    import enum_type::*;
#(
    parameter int CMD_DEPTH  = 4,
    parameter int GRAV_BASE  = 50_000_000,
    parameter int GRAV_MIN   = 3_000_000,
    parameter int MAX_LEVEL  = 7,
    parameter int BAR_PERIOD = 16
`ifdef TETRIS_AUTO_REPEAT_EN
    ,
    parameter int DAS_DELAY  = 10_000_000,
    parameter int DAS_RATE   = 2_500_000
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_rot,
    input  logic                 btn_rot_rev,
    input  logic                 btn_down,
    input  logic                 btn_drop,
    input  logic                 btn_hold,
`ifdef TETRIS_AUTO_REPEAT_EN
    input  logic                 hold_left,
    input  logic                 hold_right,
`endif
    input  state_type            game_state,
    input  logic [4*BCD_W-1:0]   score,
    output state_type            ctrl,
    output logic [BAR_WIDTH-1:0] bar_mask,
    output logic [3:0]           level,
    output logic                 cmd_dropped
);

    logic [3:0]           level_q, level_d;
    logic [31:0]          grav_cnt_q, grav_cnt_d;
    logic                 grav_pend_q, grav_pend_d;
    logic [15:0]          bar_cnt_q, bar_cnt_d;
    logic                 bar_pend_q, bar_pend_d;
    logic [BAR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic                 cmd_dropped_q, cmd_dropped_d;

    logic       idle, btn_any, push, pop, fifo_full, fifo_empty;
    logic       rpt_push;
    state_type  rpt_cmd, btn_cmd, push_cmd, fifo_head;
    logic [6:0] btn_vec;
    logic [7:0] lvl_raw;
    logic [31:0] period, shifted;
    logic [3:0] hole;

    assign idle    = (game_state == INIT) || (game_state == END);
    assign btn_vec = {btn_drop, btn_hold, btn_rot, btn_rot_rev, btn_left, btn_right, btn_down};
    assign btn_any = |btn_vec;

`ifdef TETRIS_AUTO_REPEAT_EN
    logic [31:0] das_cnt_q, das_cnt_d;

    // Counter re-enters at DELAY-RATE+1 so later repeats land every DAS_RATE cycles.
    always_comb begin
        das_cnt_d = 32'd0;
        rpt_push  = 1'b0;
        rpt_cmd   = hold_left ? LEFT : RIGHT;
        if (hold_left ^ hold_right) begin
            if (das_cnt_q == 32'(DAS_DELAY)) begin
                rpt_push  = 1'b1;
                das_cnt_d = 32'(DAS_DELAY - DAS_RATE + 1);
            end else begin
                das_cnt_d = das_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) das_cnt_q <= 32'd0;
        else          das_cnt_q <= das_cnt_d;
    end
`else
    assign rpt_push = 1'b0;
    assign rpt_cmd  = NONE;
`endif

    always_comb begin
        btn_cmd = NONE;
        if      (btn_drop)    btn_cmd = DROP;
        else if (btn_hold)    btn_cmd = HOLD;
        else if (btn_rot)     btn_cmd = ROTATE;
        else if (btn_rot_rev) btn_cmd = ROTATE_REV;
        else if (btn_left)    btn_cmd = LEFT;
        else if (btn_right)   btn_cmd = RIGHT;
        else if (btn_down)    btn_cmd = DOWN;
        push_cmd = btn_any ? btn_cmd : rpt_cmd;
    end

    // Issue path: bars beat gravity beat queued buttons; nothing leaves outside WAIT.
    always_comb begin
        ctrl        = NONE;
        pop         = 1'b0;
        grav_pend_d = grav_pend_q;
        bar_pend_d  = bar_pend_q;
        if (reset_n) begin
            if (idle) begin
                ctrl = btn_any ? DOWN : NONE;
            end else if (game_state == WAIT) begin
                if (bar_pend_q) begin
                    ctrl       = BAR;
                    bar_pend_d = 1'b0;
                end else if (grav_pend_q) begin
                    ctrl        = DOWN;
                    grav_pend_d = 1'b0;
                end else if (!fifo_empty) begin
                    ctrl = fifo_head;
                    pop  = 1'b1;
                end
            end
        end
        push          = reset_n && !idle && (btn_any || rpt_push);
        cmd_dropped_d = !idle && btn_any &&
                        (($countones(btn_vec) > 1) || (fifo_full && !pop));

        lvl_raw = 8'(score[11:8]) + 8'(score[15:12]) * 8'd10;
        level_d = (lvl_raw > 8'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : lvl_raw[3:0];
        shifted = 32'(GRAV_BASE) >> level_q;
        period  = (shifted < 32'(GRAV_MIN)) ? 32'(GRAV_MIN) : shifted;

        grav_cnt_d = grav_cnt_q;
        bar_cnt_d  = bar_cnt_q;
        if (idle) begin
            grav_cnt_d  = 32'd0;
            grav_pend_d = 1'b0;
            bar_cnt_d   = 16'd0;
            bar_pend_d  = 1'b0;
        end else if (grav_cnt_q >= period - 32'd1) begin
            // A fresh tick wins over a same-cycle clear; pending ticks never stack.
            grav_cnt_d  = 32'd0;
            grav_pend_d = 1'b1;
            if (BAR_PERIOD != 0) begin
                if (bar_cnt_q == 16'(BAR_PERIOD - 1)) begin
                    bar_cnt_d  = 16'd0;
                    bar_pend_d = 1'b1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 16'd1;
                end
            end
        end else begin
            grav_cnt_d = grav_cnt_q + 32'd1;
        end

        lfsr_d = {lfsr_q[BAR_WIDTH-2:0], lfsr_q[9] ^ lfsr_q[6]};
        hole   = (lfsr_q[3:0] >= 4'd10) ? lfsr_q[3:0] - 4'd10 : lfsr_q[3:0];
    end

    assign bar_mask    = ~(BAR_WIDTH'(1) << hole);
    assign level       = level_q;
    assign cmd_dropped = cmd_dropped_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_q       <= 4'd0;
            grav_cnt_q    <= 32'd0;
            grav_pend_q   <= 1'b0;
            bar_cnt_q     <= 16'd0;
            bar_pend_q    <= 1'b0;
            lfsr_q        <= LFSR_SEED;
            cmd_dropped_q <= 1'b0;
        end else begin
            level_q       <= level_d;
            grav_cnt_q    <= grav_cnt_d;
            grav_pend_q   <= grav_pend_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_pend_q    <= bar_pend_d;
            lfsr_q        <= lfsr_d;
            cmd_dropped_q <= cmd_dropped_d;
        end
    end

    cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (idle),
        .push    (push),
        .pop     (pop),
        .din     (push_cmd),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_tetris_cmd_sched.sv
// Directed plus random bench for tetris_cmd_sched against a queue-based reference model.
module tb_tetris_cmd_sched;
    import enum_type::*;

    localparam int DEPTH = 4;
    localparam int GB    = 16;
    localparam int GM    = 4;
    localparam int ML    = 7;
    localparam int BP    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        b_left, b_right, b_rot, b_rot_rev, b_down, b_drop, b_hold;
    state_type   gs;
    logic [15:0] score;
    state_type   ctrl;
    logic [9:0]  bar_mask;
    logic [3:0]  level;
    logic        cmd_dropped;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    state_type  mq[$];
    int         gcnt, bcnt, mlvl;
    bit         gpend, bpend, mdrop;
    logic [9:0] mlfsr;

    tetris_cmd_sched #(
        .CMD_DEPTH(DEPTH), .GRAV_BASE(GB), .GRAV_MIN(GM), .MAX_LEVEL(ML), .BAR_PERIOD(BP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_left    (b_left),
        .btn_right   (b_right),
        .btn_rot     (b_rot),
        .btn_rot_rev (b_rot_rev),
        .btn_down    (b_down),
        .btn_drop    (b_drop),
        .btn_hold    (b_hold),
`ifdef TETRIS_AUTO_REPEAT_EN
        .hold_left   (1'b0),
        .hold_right  (1'b0),
`endif
        .game_state  (gs),
        .score       (score),
        .ctrl        (ctrl),
        .bar_mask    (bar_mask),
        .level       (level),
        .cmd_dropped (cmd_dropped)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [6:0] v);
        {b_drop, b_hold, b_rot, b_rot_rev, b_left, b_right, b_down} = v;
    endtask

    function automatic state_type exp_ctrl();
        if (!reset_n) return NONE;
        if (gs == INIT || gs == END)
            return (b_drop | b_hold | b_rot | b_rot_rev | b_left | b_right | b_down) ? DOWN : NONE;
        if (gs == WAIT) begin
            if (bpend) return BAR;
            if (gpend) return DOWN;
            if (mq.size() > 0) return mq[0];
        end
        return NONE;
    endfunction

    task automatic model_reset();
        mq.delete();
        gcnt = 0; bcnt = 0; mlvl = 0;
        gpend = 0; bpend = 0; mdrop = 0;
        mlfsr = 10'h001;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        state_type ec;
        state_type pressed[$];
        int hole, period, digits;
        @(negedge clk);
        ec   = exp_ctrl();
        hole = int'(mlfsr[3:0]) % 10;
        chk("ctrl", ctrl, ec);
        chk("level", level, mlvl);
        chk("cmd_dropped", cmd_dropped, mdrop);
        chk("bar_mask", bar_mask, 10'h3ff & ~(32'd1 << hole));
        chk("bar_mask_ones", $countones(bar_mask), 9);
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            period = GB >> mlvl;
            if (period < GM) period = GM;
            digits = int'(score[11:8]) + 10 * int'(score[15:12]);
            mlfsr  = {mlfsr[8:0], mlfsr[9] ^ mlfsr[6]};
            mdrop  = 0;
            if (gs == INIT || gs == END) begin
                mq.delete();
                gcnt = 0; bcnt = 0; gpend = 0; bpend = 0;
            end else begin
                if (gs == WAIT) begin
                    if (bpend) bpend = 0;
                    else if (gpend) gpend = 0;
                    else if (mq.size() > 0) void'(mq.pop_front());
                end
                if (gcnt >= period - 1) begin
                    gcnt  = 0;
                    gpend = 1;
                    if (bcnt == BP - 1) begin bcnt = 0; bpend = 1; end
                    else bcnt++;
                end else begin
                    gcnt++;
                end
                if (b_drop)    pressed.push_back(DROP);
                if (b_hold)    pressed.push_back(HOLD);
                if (b_rot)     pressed.push_back(ROTATE);
                if (b_rot_rev) pressed.push_back(ROTATE_REV);
                if (b_left)    pressed.push_back(LEFT);
                if (b_right)   pressed.push_back(RIGHT);
                if (b_down)    pressed.push_back(DOWN);
                if (pressed.size() > 0) begin
                    if (mq.size() < DEPTH) mq.push_back(pressed[0]);
                    else mdrop = 1;
                    if (pressed.size() > 1) mdrop = 1;
                end
            end
            mlvl = (digits > ML) ? ML : digits;
        end
        #1;
    endtask

    task automatic run(input state_type s, input logic [6:0] btn, input int n);
        gs = s;
        set_btn(btn);
        for (int i = 0; i < n; i++) tick();
        set_btn(7'd0);
    endtask

    initial begin
        state_type st[10];
        st = '{INIT, GEN, GEN, WAIT, WAIT, WAIT, CLEAR, LEFT, DROP, END};
        reset_n = 1'b0;
        gs      = INIT;
        score   = 16'h0000;
        set_btn(7'd0);
        model_reset();
        @(posedge clk);
        #1;
        run(INIT, 7'd0, 2);
        reset_n = 1'b1;

        // Start press while in INIT: single DOWN, nothing queued
        run(INIT, 7'b0000100, 1);
        run(INIT, 7'd0, 2);
        run(WAIT, 7'd0, 2);

        // Queued ROTATE then LEFT issued across two WAIT visits
        run(GEN, 7'b0010000, 1);
        run(GEN, 7'd0, 1);
        run(GEN, 7'b0000100, 1);
        run(WAIT, 7'd0, 1);
        run(GEN, 7'd0, 1);
        run(WAIT, 7'd0, 1);

        // DROP+LEFT together, then overfill
        run(GEN, 7'b1000100, 1);
        run(GEN, 7'd0, 1);
        for (int i = 0; i < 5; i++) run(GEN, 7'b0000010, 1);
        run(GEN, 7'd0, 1);
        run(WAIT, 7'd0, 8);

        // Level 2: period 4, gravity and bars in WAIT
        score = 16'h0200;
        run(WAIT, 7'd0, 20);
        run(GEN, 7'b0000100, 1);
        run(GEN, 7'd0, 6);
        run(WAIT, 7'd0, 6);

        // Level clamp and reset mid-operation
        score = 16'h1500;
        run(GEN, 7'b0100000, 1);
        run(WAIT, 7'd0, 4);
        reset_n = 1'b0;
        run(WAIT, 7'b0000001, 2);
        reset_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                score = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 8'($urandom)};
            if ($urandom_range(0, 3) == 0) gs = st[$urandom_range(0, 9)];
            set_btn({$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0});
            reset_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset_n = 1'b1;
        set_btn(7'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
